// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter_if
// Description : Requester A/B job ports and result handshake of the shared
//               logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             a_req;
   logic [1:0]       a_op;
   logic [WIDTH-1:0] a_x;
   logic [WIDTH-1:0] a_y;
   logic             a_ack;
   logic             b_req;
   logic [1:0]       b_op;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] b_y;
   logic             b_ack;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             res_src;
   logic             res_ready;
   logic             busy;

   // Requesters and result consumer
   modport master (
      output a_req, a_op, a_x, a_y, b_req, b_op, b_x, b_y, res_ready,
      input  a_ack, b_ack, res_valid, res_data, res_src, busy
   );

   // Shared logic unit
   modport slave (
      input  a_req, a_op, a_x, a_y, b_req, b_op, b_x, b_y, res_ready,
      output a_ack, b_ack, res_valid, res_data, res_src, busy
   );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin shared NOT/AND/OR/XOR unit for two requesters,
//               sequenced IDLE -> EXEC -> DONE with back-to-back grants.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
   parameter int WIDTH = 8
) (
   input  wire                   clk,
   input  wire                   rst,
   logic_unit_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [1:0] c_OP_NOT = 2'b00;
   localparam logic [1:0] c_OP_AND = 2'b01;
   localparam logic [1:0] c_OP_OR  = 2'b10;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last;        // 0 = A, 1 = B
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_job_src;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_src;

   logic             w_any_req;
   logic             w_pick_b;
   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_accept;
   logic [WIDTH-1:0] w_result;

   assign w_any_req = bus.a_req | bus.b_req;
   // On a tie the requester that did not win last time is chosen.
   assign w_pick_b  = (bus.a_req & bus.b_req) ? ~r_last : bus.b_req;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_a   = 1'b0;
      w_grant_b   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_grant_a   = ~w_pick_b;
               w_grant_b   = w_pick_b;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (r_res_valid && bus.res_ready) begin
               w_accept = 1'b1;
               if (w_any_req) begin
                  w_grant_a   = ~w_pick_b;
                  w_grant_b   = w_pick_b;
                  w_state_nxt = S_EXEC;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (rst) begin
         w_grant_a = 1'b0;
         w_grant_b = 1'b0;
      end
   end

   always_comb begin
      w_result = '0;
      case (r_op)
         c_OP_NOT: w_result = ~r_x;
         c_OP_AND: w_result = r_x & r_y;
         c_OP_OR:  w_result = r_x | r_y;
         default:  w_result = r_x ^ r_y;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_op        <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_job_src   <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_src   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_a) begin
            r_last    <= 1'b0;
            r_op      <= bus.a_op;
            r_x       <= bus.a_x;
            r_y       <= bus.a_y;
            r_job_src <= 1'b0;
         end else if (w_grant_b) begin
            r_last    <= 1'b1;
            r_op      <= bus.b_op;
            r_x       <= bus.b_x;
            r_y       <= bus.b_y;
            r_job_src <= 1'b1;
         end
         if (r_state == S_EXEC) begin
            r_res_data  <= w_result;
            r_res_src   <= r_job_src;
            r_res_valid <= 1'b1;
         end else if (w_accept) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign bus.a_ack     = w_grant_a;
   assign bus.b_ack     = w_grant_b;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_src   = r_res_src;
   assign bus.busy      = ~rst & (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Vector table plus directed sequences with a result scoreboard
//               for logic_unit_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   typedef struct packed {
      logic             src;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic       rst;
      logic       a_req;
      logic [1:0] a_op;
      logic [7:0] a_x;
      logic [7:0] a_y;
      logic       b_req;
      logic [1:0] b_op;
      logic [7:0] b_x;
      logic [7:0] b_y;
      logic       rdy;
      logic       e_a;
      logic       e_b;
      logic       e_v;
      logic [7:0] e_d;
      logic       e_s;
      logic       e_busy;
      int         mode;   // 0: acks/busy, 1: +valid, 2: +data/src
   } vec_t;

   vec_t tbl[16];

   logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus();

   logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
      case (op)
         2'd0:    return ~x;
         2'd1:    return x & y;
         2'd2:    return x | y;
         default: return x ^ y;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard: expected results queued at grants, retired at accepts.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.a_ack && bus.b_ack)
            chk("ack_exclusive", 32'd1, 32'd0);
         if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_result", {23'd0, bus.res_src, bus.res_data}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_data", {24'd0, bus.res_data}, {24'd0, e.data});
               chk("sb_src", {31'd0, bus.res_src}, {31'd0, e.src});
            end
         end
         if (bus.a_ack) sb.push_back('{1'b0, model(bus.a_op, bus.a_x, bus.a_y)});
         if (bus.b_ack) sb.push_back('{1'b1, model(bus.b_op, bus.b_x, bus.b_y)});
      end
   end

   task automatic drive(input logic r, input logic ar, input logic [1:0] aop, input logic [7:0] ax,
                        input logic [7:0] ay, input logic br, input logic [1:0] bop,
                        input logic [7:0] bx, input logic [7:0] by, input logic rdy);
      @(posedge clk);
      #1;
      rst = r;
      bus.a_req = ar; bus.a_op = aop; bus.a_x = ax; bus.a_y = ay;
      bus.b_req = br; bus.b_op = bop; bus.b_x = bx; bus.b_y = by;
      bus.res_ready = rdy;
   endtask

   task automatic expect_out(input string nm, input logic ea, input logic eb, input logic ev,
                             input logic [7:0] ed, input logic es, input logic ebusy, input int mode);
      @(negedge clk);
      chk({nm, ".a_ack"}, {31'd0, bus.a_ack}, {31'd0, ea});
      chk({nm, ".b_ack"}, {31'd0, bus.b_ack}, {31'd0, eb});
      chk({nm, ".busy"}, {31'd0, bus.busy}, {31'd0, ebusy});
      if (mode >= 1)
         chk({nm, ".res_valid"}, {31'd0, bus.res_valid}, {31'd0, ev});
      if (mode >= 2) begin
         chk({nm, ".res_data"}, {24'd0, bus.res_data}, {24'd0, ed});
         chk({nm, ".res_src"}, {31'd0, bus.res_src}, {31'd0, es});
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.a_req = 0; bus.a_op = 0; bus.a_x = 0; bus.a_y = 0;
      bus.b_req = 0; bus.b_op = 0; bus.b_x = 0; bus.b_y = 0;
      bus.res_ready = 0;

      //         rst a  aop  ax     ay     b  bop  bx     by     rdy  ea eb ev ed     es busy mode
      tbl[0]  = '{1, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 0,  0, 0, 0, 8'h00, 0, 0, 0};
      tbl[1]  = '{1, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 0,  0, 0, 0, 8'h00, 0, 0, 2};
      tbl[2]  = '{0, 1, 2'd0, 8'h5A, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0, 2};
      tbl[3]  = '{0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1, 2};
      tbl[4]  = '{0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1,  0, 0, 1, 8'hA5, 0, 1, 2};
      tbl[5]  = '{1, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 1};
      tbl[6]  = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  1, 0, 0, 8'h00, 0, 0, 2};
      tbl[7]  = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  0, 0, 0, 8'h00, 0, 1, 1};
      tbl[8]  = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  0, 1, 1, 8'h30, 0, 1, 2};
      tbl[9]  = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  0, 0, 0, 8'h00, 0, 1, 1};
      tbl[10] = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  1, 0, 1, 8'hCC, 1, 1, 2};
      tbl[11] = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  0, 0, 0, 8'h00, 0, 1, 1};
      tbl[12] = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  0, 1, 1, 8'h30, 0, 1, 2};
      tbl[13] = '{0, 1, 2'd1, 8'hF0, 8'h3C, 1, 2'd3, 8'hF0, 8'h3C, 1,  0, 0, 0, 8'h00, 0, 1, 1};
      tbl[14] = '{0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1,  0, 0, 1, 8'hCC, 1, 1, 2};
      tbl[15] = '{0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 1};

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].rst, tbl[i].a_req, tbl[i].a_op, tbl[i].a_x, tbl[i].a_y,
               tbl[i].b_req, tbl[i].b_op, tbl[i].b_x, tbl[i].b_y, tbl[i].rdy);
         expect_out($sformatf("vec%0d", i), tbl[i].e_a, tbl[i].e_b, tbl[i].e_v,
                    tbl[i].e_d, tbl[i].e_s, tbl[i].e_busy, tbl[i].mode);
      end

      // Back-pressure: B result held while A waits without an ack.
      drive(0, 0, 2'd0, 8'h0F, 8'h00, 1, 2'd2, 8'h81, 8'h18, 0);
      expect_out("bp_grant_b", 0, 1, 0, 8'h00, 0, 0, 1);
      drive(0, 1, 2'd0, 8'h0F, 8'h00, 0, 2'd2, 8'h00, 8'h00, 0);
      expect_out("bp_exec", 0, 0, 0, 8'h00, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 2'd0, 8'h0F, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
         expect_out($sformatf("bp_hold%0d", i), 0, 0, 1, 8'h99, 1, 1, 2);
      end
      drive(0, 1, 2'd0, 8'h0F, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
      expect_out("bp_release", 1, 0, 1, 8'h99, 1, 1, 2);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("bp_a_exec", 0, 0, 0, 8'h00, 0, 1, 1);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
      expect_out("bp_a_done", 0, 0, 1, 8'hF0, 0, 1, 2);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("bp_idle", 0, 0, 0, 8'h00, 0, 0, 1);

      // Withdrawal: A raised during EXEC and dropped before DONE completes.
      drive(0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd1, 8'hFF, 8'h0F, 0);
      expect_out("wd_grant_b", 0, 1, 0, 8'h00, 0, 0, 1);
      drive(0, 1, 2'd3, 8'h00, 8'hFF, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("wd_exec", 0, 0, 0, 8'h00, 0, 1, 1);
      drive(0, 1, 2'd3, 8'h00, 8'hFF, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("wd_done", 0, 0, 1, 8'h0F, 1, 1, 2);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
      expect_out("wd_accept", 0, 0, 1, 8'h0F, 1, 1, 2);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("wd_idle", 0, 0, 0, 8'h00, 0, 0, 1);

      // Reset during EXEC, then during DONE; a tie afterwards goes to A.
      drive(0, 1, 2'd2, 8'h11, 8'h22, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_grant1", 1, 0, 0, 8'h00, 0, 0, 1);
      drive(1, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_rst_exec", 0, 0, 0, 8'h00, 0, 0, 0);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      sb.delete();
      expect_out("rm_after1", 0, 0, 0, 8'h00, 0, 0, 2);
      drive(0, 1, 2'd3, 8'h11, 8'h22, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_grant2", 1, 0, 0, 8'h00, 0, 0, 1);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_exec2", 0, 0, 0, 8'h00, 0, 1, 1);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_done2", 0, 0, 1, 8'h33, 0, 1, 2);
      drive(1, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_rst_done", 0, 0, 1, 8'h33, 0, 0, 0);
      drive(0, 1, 2'd0, 8'hC3, 8'h00, 1, 2'd1, 8'hAA, 8'h55, 1);
      sb.delete();
      expect_out("rm_tie", 1, 0, 0, 8'h00, 0, 0, 2);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
      expect_out("rm_tie_exec", 0, 0, 0, 8'h00, 0, 1, 1);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
      expect_out("rm_tie_done", 0, 0, 1, 8'h3C, 0, 1, 2);
      drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      expect_out("rm_idle", 0, 0, 0, 8'h00, 0, 0, 1);

      chk("sb_leftover", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one WIDTH-bit logic unit (NOT/AND/OR/XOR) between two requesters, A and B, using a round-robin arbiter. A three-state FSM sequences each job: grant and operand capture, a registered execute stage, and a result held until the consumer accepts it. It sits between the pin-level input decode and the `uo_out` driver of the top-level wrapper, replacing the fixed inverter path with a shared, scheduled resource.

## Interface
Parameters:
- `WIDTH`, default 8, operand and result width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `a_req`  in  1  requester A has a job pending; held high until `a_ack`.
- `a_op`  in  2  A opcode: 00 NOT x, 01 x AND y, 10 x OR y, 11 x XOR y.
- `a_x`, `a_y`  in  WIDTH each  A operands; `a_y` is ignored for NOT.
- `a_ack`  out  1  combinational pulse; A's operands are captured at this edge.
- `b_req`, `b_op`, `b_x`, `b_y`, `b_ack`  same as the A ports, for requester B.
- `res_valid`  out  1  result available.
- `res_data`  out  WIDTH  result.
- `res_src`  out  1  source of the result: 0 = A, 1 = B.
- `res_ready`  in  1  consumer accepts the result when high together with `res_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
FSM states:
- **IDLE**
  - No request: stay in IDLE.
  - Any `req`: grant one requester, assert its `ack`, latch op/x/y/src, go to EXEC.
- **EXEC**
  - Compute the opcode result into the `res_data` register.
  - Set `res_valid` = 1 and go to DONE.
  - `req` inputs are not sampled in this state.
- **DONE**
  - Hold `res_valid`, `res_data` and `res_src` stable while `res_ready` = 0.
  - On `res_valid` && `res_ready` with no `req` pending: clear `res_valid`, go to IDLE.
  - On `res_valid` && `res_ready` with a `req` pending: grant in the same cycle (back-to-back), latch the new job, clear `res_valid`, go to EXEC.

Arbitration:
- Round-robin pointer `last` records the most recent grant.
- If only one requester is asserting `req`, it wins.
- If both are asserting, the requester ≠ `last` wins.
- `last` updates only on a grant.
- Reset value of `last` = B, so A wins the first tie.
- At most one `ack` is high in any cycle. `ack` is high only in a granting cycle.

Arithmetic:
- Pure bitwise, WIDTH bits.
- NOT returns `~x`.

Requester rules:
- Dropping `req` before `ack` withdraws the request; no error is flagged.
- Operands may change freely after `ack`.

Reset (`rst` = 1 at an edge), including mid-job:
- State = IDLE, `last` = B.
- `res_valid` = 0, `res_data` = 0, `res_src` = 0.
- Any in-flight job is discarded; no `ack` is issued during reset.
- Output values while in reset: `busy` = 0, `a_ack` = `b_ack` = 0.

## Timing
- Grant in cycle N (`ack` high, operands sampled at the end of N). EXEC in cycle N+1. `res_valid` = 1 from cycle N+2.
- Latency is 2 cycles from `ack` to `res_valid`.
- Best-case throughput is one job per 2 cycles, using back-to-back grants from DONE with `res_ready` held at 1.
- `ack` is combinational from `req`, state and `last`. All other outputs are registered.
- Back-pressure: `res_ready` = 0 holds DONE indefinitely. Pending requesters wait; their `ack` stays low.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with both requests high → `a_ack` = `b_ack` = 0, `res_valid` = 0, `res_data` = 0x00, `busy` = 0.
- **Single NOT:** `a_req` = 1, `a_op` = 00, `a_x` = 0x5A → `a_ack` in cycle N; `res_valid` = 1 in N+2 with `res_data` = 0xA5, `res_src` = 0.
- **Tie fairness:** both requests held, A = AND(0xF0, 0x3C), B = XOR(0xF0, 0x3C), `res_ready` = 1 → results in order A (0x30), B (0xCC), A, B. `ack`s alternate, never both high, and a job issues every 2 cycles.
- **Back-pressure:** B = OR(0x81, 0x18), `res_ready` = 0 for 5 cycles while `a_req` = 1 → `res_data` holds 0x99 and `res_src` = 1 throughout; `a_ack` stays low until the cycle `res_ready` rises, then A is granted in that same cycle.
- **Withdrawal:** raise `a_req` while the unit is in EXEC, drop it before DONE completes → no `a_ack`; FSM returns to IDLE.
- **Reset mid-job:** assert `rst` in EXEC and again in DONE with `res_ready` = 0 → next cycle `res_valid` = 0 and `busy` = 0; a subsequent tie grants A first.
